// File: rtl/multiword_adder_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared 4-bit adder, LSB nibble first.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    request handshake; op_sub, a, b, cin are the request payload
//   out_valid/out_ready  response handshake; sum, cout, ovf are the response payload
//   busy                 high while an operation is running or its result is held

// 4-bit adder composed of two chained 2-bit slices.
module fourBitAdder_TwoByTwo (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [2:0] lo;
  logic [2:0] hi;

  assign lo   = 3'(a[1:0]) + 3'(b[1:0]) + 3'(cin);
  assign hi   = 3'(a[3:2]) + 3'(b[3:2]) + 3'(lo[2]);
  assign sum  = {hi[1:0], lo[1:0]};
  assign cout = hi[2];
endmodule

module multiword_adder_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic             last_nib;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_c;

  assign last_nib = (idx_q == IW'(NIB - 1));
  assign nib_a    = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b    = b_q[{idx_q, 2'b00} +: 4];

  fourBitAdder_TwoByTwo u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_s),
    .cout (nib_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_n = RUN;
      RUN:     if (last_nib)             state_n = DONE;
      DONE:    if (out_ready)            state_n = IDLE;
      default:                           state_n = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
    end
  end

  // Operand latch and nibble-serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q     <= a;
            // Subtract as a + ~b + 1.
            b_q     <= b ^ {WIDTH{op_sub}};
            carry_q <= op_sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          sum[{idx_q, 2'b00} +: 4] <= nib_s;
          carry_q                  <= nib_c;
          if (last_nib) begin
            idx_q <= '0;
            cout  <= nib_c;
            ovf   <= (a_q[WIDTH-1] ^ nib_s[3]) & (b_q[WIDTH-1] ^ nib_s[3]);
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_adder_sequencer.sv
module tb_multiword_adder_sequencer;
  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multiword_adder_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic             sub;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vcin;
    logic [WIDTH-1:0] esum;
    logic             ecout;
    logic             eovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; returns the number of cycles until out_valid (0 on timeout).
  task automatic start_op(input logic s, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vc, output int lat);
    lat = 0;
    check("in_ready_before_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_sub   = s;
    a        = va;
    b        = vb;
    cin      = vc;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = ~va;
      b        = ~vb;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
    check("busy_after_take", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] held;

    vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 16'h00FF, 16'h0001, 1'b1, 16'h0101, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'h0010, 16'h0010, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_sum", 32'(sum), 32'h0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);

    // Table-driven operations.
    foreach (vecs[k]) begin
      start_op(vecs[k].sub, vecs[k].va, vecs[k].vb, vecs[k].vcin, lat);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'd5);
      check($sformatf("v%0d_sum", k), 32'(sum), 32'(vecs[k].esum));
      check($sformatf("v%0d_cout", k), 32'(cout), 32'(vecs[k].ecout));
      check($sformatf("v%0d_ovf", k), 32'(ovf), 32'(vecs[k].eovf));
      check($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
      check($sformatf("v%0d_in_ready_done", k), 32'(in_ready), 32'd0);
      release_result();
    end

    // Result held under backpressure; new requests ignored while DONE.
    start_op(1'b0, 16'h1111, 16'h2222, 1'b0, lat);
    check("hold_latency", 32'(lat), 32'd5);
    held = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_sub   = 1'b0;
      a        = 16'(16'h0100 * (i + 1));
      b        = 16'h0001;
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    @(negedge clk);
    check("hold_no_stray_accept", 32'(busy), 32'd0);

    // Reset during the second RUN cycle aborts the operation.
    check("abort_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_sub   = 1'b0;
    a        = 16'h4321;
    b        = 16'h1234;
    cin      = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'h0);
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    check("abort_busy_after", 32'(busy), 32'd0);
    start_op(1'b0, 16'h0001, 16'h0001, 1'b0, lat);
    check("post_abort_latency", 32'(lat), 32'd5);
    check("post_abort_sum", 32'(sum), 32'h0002);
    check("post_abort_cout", 32'(cout), 32'd0);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
